// File: rtl/instr_loader.sv
// Byte-stream to instruction-memory writer: packs big-endian bytes into 32-bit words.
// Optional trailing checksum phase enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

`ifdef INSTR_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHK, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W:0]     r_num;
   logic [ADDR_W:0]     r_count;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_idx;
   logic [31:0]         r_word;
   logic                r_err;
   logic                w_start_ok;
   logic                w_len_err;
   logic                w_xfer;
   logic                w_last;
   logic [ADDR_W:0]     w_count_inc;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [31:0]         r_sum;
   logic [31:0]         r_chk;
   logic                w_chk_xfer;
`endif

   assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_len_err   = (num_words > DEPTH);
   assign w_xfer      = byte_valid && (r_state == S_RECV);
   assign w_count_inc = r_count + (ADDR_W+1)'(1);
   assign w_last      = (w_count_inc == r_num);
`ifdef INSTR_LOADER_CHECKSUM_EN
   assign w_chk_xfer  = byte_valid && (r_state == S_CHK);
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_start_ok) begin
               if (w_len_err)
                  w_state_nxt = S_DONE;
               else if (num_words == '0)
`ifdef INSTR_LOADER_CHECKSUM_EN
                  w_state_nxt = S_CHK;
`else
                  w_state_nxt = S_DONE;
`endif
               else
                  w_state_nxt = S_RECV;
            end
         end
         S_RECV: if (w_xfer && r_idx == 2'd3) w_state_nxt = S_WRITE;
         S_WRITE: begin
            if (w_last)
`ifdef INSTR_LOADER_CHECKSUM_EN
               w_state_nxt = S_CHK;
`else
               w_state_nxt = S_DONE;
`endif
            else
               w_state_nxt = S_RECV;
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         S_CHK: if (w_chk_xfer && r_idx == 2'd3) w_state_nxt = S_DONE;
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: the shift register leaves the first byte in bits [31:24] after four transfers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_num   <= '0;
         r_count <= '0;
         r_addr  <= '0;
         r_idx   <= '0;
         r_word  <= '0;
         r_err   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         r_sum   <= '0;
         r_chk   <= '0;
`endif
      end else if (w_start_ok) begin
         r_num   <= num_words;
         r_count <= '0;
         r_addr  <= '0;
         r_idx   <= '0;
         r_err   <= w_len_err;
`ifdef INSTR_LOADER_CHECKSUM_EN
         r_sum   <= '0;
`endif
      end else begin
         if (w_xfer) begin
            r_word <= {r_word[23:0], byte_in};
            r_idx  <= r_idx + 2'd1;
         end
         if (r_state == S_WRITE) begin
            r_count <= w_count_inc;
            // Address stays on the last written word so a full load never wraps to 0
            if (!w_last) r_addr <= r_addr + ADDR_W'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_sum <= r_sum + r_word;
`endif
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         if (w_chk_xfer) begin
            r_chk <= {r_chk[23:0], byte_in};
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_err <= ({r_chk[23:0], byte_in} != r_sum);
         end
`endif
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   assign byte_ready = (r_state == S_RECV) || (r_state == S_CHK);
   assign busy       = (r_state == S_RECV) || (r_state == S_WRITE) || (r_state == S_CHK);
`else
   assign byte_ready = (r_state == S_RECV);
   assign busy       = (r_state == S_RECV) || (r_state == S_WRITE);
`endif
   assign mem_we     = (r_state == S_WRITE);
   assign done       = (r_state == S_DONE);
   assign err        = r_err;
   assign mem_addr   = r_addr;
   assign mem_wdata  = r_word;
   assign word_count = r_count;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a write scoreboard checked on every mem_we.
module tb_instr_loader;
   localparam int ADDR_W = 5;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   num_words = '0;
   logic [7:0]        byte_in = '0;
   logic              byte_valid = 1'b0;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   word_count;

   int n_checks = 0;
   int n_errors = 0;
   logic [36:0] exp_q[$];

   instr_loader #(.ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .num_words(num_words),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .err(err), .word_count(word_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected (addr, data)
   always @(negedge clock) begin
      if (reset_n && mem_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {27'd0, mem_addr}, 32'hFFFF_FFFF);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("wr_addr", {27'd0, mem_addr}, {27'd0, e[36:32]});
            check("wr_data", mem_wdata, e[31:0]);
            check("ready_in_write", {31'd0, byte_ready}, 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic do_start(input logic [ADDR_W:0] n);
      num_words = n; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int g = 0;
      if (gap) begin byte_valid = 1'b0; tick(); end
      byte_in = b; byte_valid = 1'b1;
      while (!byte_ready && g < 50) begin tick(); g++; end
      if (!byte_ready) check("byte_ready_timeout", 32'd0, 32'd1);
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic wait_done();
      int g = 0;
      while (!done && g < 400) begin tick(); g++; end
      check("done_reached", {31'd0, done}, 32'd1);
   endtask

   initial begin
      logic [31:0] w;
      // Reset state
      tick(); tick();
      check("rst_ready", {31'd0, byte_ready}, 0);
      check("rst_we", {31'd0, mem_we}, 0);
      check("rst_busy_done_err", {29'd0, busy, done, err}, 0);
      check("rst_addr_cnt", {21'd0, mem_addr, word_count}, 0);
      check("rst_wdata", mem_wdata, 0);
      reset_n = 1'b1;
      tick();

      // Two words, valid held high
      exp_q.push_back({5'd0, 32'h1234_5678});
      exp_q.push_back({5'd1, 32'h9ABC_DEF0});
      do_start(2);
      check("busy_after_start", {31'd0, busy}, 1);
      check("ready_after_start", {31'd0, byte_ready}, 1);
      send_word(32'h1234_5678, 0);
      check("we_after_4th", {31'd0, mem_we}, 1);
      tick();
      check("ready_back", {31'd0, byte_ready}, 1);
      send_word(32'h9ABC_DEF0, 0);
      check("we_last", {31'd0, mem_we}, 1);
      tick();
      check("done_next", {31'd0, done}, 1);
      check("err_ok", {31'd0, err}, 0);
      check("count2", {26'd0, word_count}, 2);
      check("busy_done", {31'd0, busy}, 0);
      check("sb_empty1", exp_q.size(), 0);

      // Same load with gaps in byte_valid
      exp_q.push_back({5'd0, 32'h1234_5678});
      exp_q.push_back({5'd1, 32'h9ABC_DEF0});
      do_start(2);
      send_word(32'h1234_5678, 1);
      send_word(32'h9ABC_DEF0, 1);
      wait_done();
      check("gap_count", {26'd0, word_count}, 2);
      check("gap_err", {31'd0, err}, 0);
      check("sb_empty2", exp_q.size(), 0);

      // Oversized length: immediate error, nothing written
      do_start(33);
      check("len_err_done", {31'd0, done}, 1);
      check("len_err_err", {31'd0, err}, 1);
      check("len_err_count", {26'd0, word_count}, 0);
      tick(); tick();

`ifndef INSTR_LOADER_CHECKSUM_EN
      // Zero-length load
      do_start(0);
      check("zero_done", {31'd0, done}, 1);
      check("zero_err", {31'd0, err}, 0);
`endif

      // start during RECV is ignored
      exp_q.push_back({5'd0, 32'hCAFE_F00D});
      do_start(1);
      send_byte(8'hCA, 0);
      send_byte(8'hFE, 0);
      do_start(5);
      check("ignored_busy", {31'd0, busy}, 1);
      send_byte(8'hF0, 0);
      send_byte(8'h0D, 0);
      wait_done();
      check("ignored_count", {26'd0, word_count}, 1);
      check("sb_empty3", exp_q.size(), 0);

      // Full-depth load, no wrap
      do_start(32);
      for (int i = 0; i < 32; i++) begin
         w = $urandom;
         exp_q.push_back({i[4:0], w});
         send_word(w, 0);
      end
      wait_done();
      check("full_count", {26'd0, word_count}, 32);
      check("full_last_addr", {27'd0, mem_addr}, 31);
      check("full_err", {31'd0, err}, 0);
      check("sb_empty4", exp_q.size(), 0);

`ifdef INSTR_LOADER_CHECKSUM_EN
      exp_q.push_back({5'd0, 32'h0000_0001});
      do_start(1);
      send_word(32'h0000_0001, 0);
      send_word(32'h0000_0001, 0);
      wait_done();
      check("chk_good_err", {31'd0, err}, 0);
      exp_q.push_back({5'd0, 32'h0000_0001});
      do_start(1);
      send_word(32'h0000_0001, 0);
      send_word(32'h0000_0002, 0);
      wait_done();
      check("chk_bad_err", {31'd0, err}, 1);
`endif

      // Reset mid-load after one word written
      exp_q.push_back({5'd0, 32'hDEAD_BEEF});
      do_start(3);
      send_word(32'hDEAD_BEEF, 0);
      tick();
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      reset_n = 1'b0;
      #1;
      check("midrst_ready", {31'd0, byte_ready}, 0);
      check("midrst_busy", {31'd0, busy}, 0);
      check("midrst_data", mem_wdata, 0);
      check("midrst_count", {26'd0, word_count}, 0);
      tick(); tick();
      reset_n = 1'b1;
      tick(); tick();
      check("post_rst_idle", {29'd0, busy, done, mem_we}, 0);
      check("sb_empty5", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/instr_loader.md
# instr_loader

Writer side of the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS instruction words. Writes them into consecutive program-memory locations starting at address 0, through a single-cycle write port. Sits between the host/debug link and the instruction memory that the fetch path reads by address.

## Interface
- `ADDR_W`, 5, word-address width of program memory; depth = 2^ADDR_W words.
- `clock`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- `num_words`  in  ADDR_W+1  words to load; sampled with `start`.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  program-memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  write word address.
- `mem_wdata`  out  32  write data.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE.
- `done`  out  1  level, high in DONE.
- `err`  out  1  level, valid while `done` is high.
- `word_count`  out  ADDR_W+1  words written in the current/last load.

## Operation
- States: IDLE, RECV, WRITE, CHK (macro only), DONE.
- IDLE/DONE + `start`:
  - `num_words` > 2^ADDR_W -> DONE with `err`=1; nothing is written.
  - `num_words` = 0 -> DONE with `err`=0.
  - Otherwise -> RECV. Clears `word_count`, the byte index, the address and `err`.
- `start` is ignored in RECV, WRITE and CHK.
- RECV:
  - `byte_ready`=1.
  - A byte transfers when `byte_valid`&&`byte_ready`.
  - Byte index 0..3 maps to `mem_wdata`[31:24], [23:16], [15:8], [7:0]. The first byte is the MSB.
  - After byte 3 transfers -> WRITE.
- WRITE:
  - `byte_ready`=0, `mem_we`=1 for exactly one cycle, carrying `mem_addr` = `word_count`[ADDR_W-1:0] and the assembled word.
  - `word_count` increments at the end of the cycle.
  - If the incremented count equals `num_words` -> DONE (or CHK with macro). Otherwise -> RECV with byte index 0.
- DONE: `done`=1, `busy`=0, `byte_ready`=0, outputs hold until the next accepted `start`.
- Stalls: `byte_valid` low in RECV holds all state; there is no timeout.
- Address never wraps: a full load (`num_words` = 2^ADDR_W) ends with `mem_addr` = 2^ADDR_W−1.
- Reset mid-load:
  - The partial word is discarded.
  - Words already written stay in memory.
  - The FSM returns to IDLE.

## Timing
- Reset values:
  - `byte_ready`, `mem_we`, `busy`, `done`, `err` = 0.
  - `mem_addr`, `mem_wdata`, `word_count` = 0.
  - State = IDLE.
- All outputs are registered; none is combinational from inputs.
- `start` accepted at edge N: `busy`=1 and `byte_ready`=1 from cycle N+1.
- The 4th byte transfers at edge M: `mem_we`=1 during cycle M+1. `byte_ready` returns in cycle M+2 if the load is not finished.
- Minimum throughput: 5 cycles per word.
- Last WRITE at edge K: `done`=1 from cycle K+1 (no macro).
- Error or zero-length `start` at edge N: `done`=1 from cycle N+1.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - A 32-bit running sum (mod 2^32) of all written words is kept.
  - After the last WRITE the FSM enters CHK, with `byte_ready`=1, and accepts 4 more big-endian bytes.
  - After the 4th byte -> DONE, with `err`=1 iff the received value ≠ the sum.
  - CHK is also entered for `num_words`=0; the expected sum is then 0.
- Undefined: no CHK state and no sum register. `err` reflects only the length error.

## Test plan
- Reset with `reset_n`=0 mid-stream -> all outputs 0, state IDLE, no further `mem_we`.
- `start`, `num_words`=2, bytes 12 34 56 78 9A BC DE F0 with `byte_valid` held high:
  - `mem_we` pulses twice: addr 0 data 0x12345678, then addr 1 data 0x9ABCDEF0.
  - `done`=1, `err`=0, `word_count`=2.
- Same load with `byte_valid` toggled every other cycle -> identical writes and no duplicated bytes. `byte_ready`=0 during each WRITE cycle.
- `num_words`=33 (`ADDR_W`=5) -> `done`=1, `err`=1 the next cycle, no `mem_we`. `num_words`=32 -> last write at addr 31.
- `start` asserted during RECV -> ignored, and the load completes normally.
- With `INSTR_LOADER_CHECKSUM_EN`: one word 0x00000001 followed by checksum bytes 00 00 00 01 -> `err`=0. Checksum bytes 00 00 00 02 -> `err`=1.
